// File: rtl/kb_pkg.sv
// Shared constants, FSM state encoding and the set-2 make-code lookup
// for the keyboard key-event controller.
package kb_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SC_BREAK  = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [BYTE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [BYTE_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [BYTE_W-1:0] SC_UP     = 8'h75;
  localparam logic [BYTE_W-1:0] SC_DOWN   = 8'h72;
  localparam logic [BYTE_W-1:0] SC_LEFT   = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT  = 8'h74;

  localparam logic [BYTE_W-1:0] CH_BS    = 8'h08;
  localparam logic [BYTE_W-1:0] CH_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] CH_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] CH_UP    = 8'h11;
  localparam logic [BYTE_W-1:0] CH_DOWN  = 8'h12;
  localparam logic [BYTE_W-1:0] CH_LEFT  = 8'h13;
  localparam logic [BYTE_W-1:0] CH_RIGHT = 8'h14;
  localparam logic [BYTE_W-1:0] CASE_BIT = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } kb_state_e;

  typedef struct packed {
    logic              hit;
    logic              letter;
    logic [BYTE_W-1:0] code;
  } kb_map_t;

  // Letters return their lower-case code; the caller applies case.
  function automatic kb_map_t kb_lookup(input logic [BYTE_W-1:0] sc);
    kb_map_t m;
    m = '0;
    m.hit = 1'b1;
    m.letter = 1'b1;
    case (sc)
      8'h1C: m.code = 8'h61;  8'h32: m.code = 8'h62;  8'h21: m.code = 8'h63;
      8'h23: m.code = 8'h64;  8'h24: m.code = 8'h65;  8'h2B: m.code = 8'h66;
      8'h34: m.code = 8'h67;  8'h33: m.code = 8'h68;  8'h43: m.code = 8'h69;
      8'h3B: m.code = 8'h6A;  8'h42: m.code = 8'h6B;  8'h4B: m.code = 8'h6C;
      8'h3A: m.code = 8'h6D;  8'h31: m.code = 8'h6E;  8'h44: m.code = 8'h6F;
      8'h4D: m.code = 8'h70;  8'h15: m.code = 8'h71;  8'h2D: m.code = 8'h72;
      8'h1B: m.code = 8'h73;  8'h2C: m.code = 8'h74;  8'h3C: m.code = 8'h75;
      8'h2A: m.code = 8'h76;  8'h1D: m.code = 8'h77;  8'h22: m.code = 8'h78;
      8'h35: m.code = 8'h79;  8'h1A: m.code = 8'h7A;
      default: begin
        m.letter = 1'b0;
        case (sc)
          8'h45: m.code = 8'h30;  8'h16: m.code = 8'h31;  8'h1E: m.code = 8'h32;
          8'h26: m.code = 8'h33;  8'h25: m.code = 8'h34;  8'h2E: m.code = 8'h35;
          8'h36: m.code = 8'h36;  8'h3D: m.code = 8'h37;  8'h3E: m.code = 8'h38;
          8'h46: m.code = 8'h39;
          8'h29: m.code = CH_SPACE;
          8'h66: m.code = CH_BS;
          8'h5A: m.code = CH_CR;
          default: m.hit = 1'b0;
        endcase
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kb_key_event_ctrl_if.sv
// Scan-byte input and character-output handshake of the key-event controller.
interface kb_key_event_ctrl_if;
  import kb_pkg::*;

  logic [BYTE_W-1:0] scan_code;
  logic              scan_ready;
  logic [BYTE_W-1:0] char_data;
  logic              char_valid;
  logic              char_ready;

  // master: keyboard/consumer side; slave: the controller
  modport master (output scan_code, scan_ready, char_ready,
                  input  char_data, char_valid);
  modport slave  (input  scan_code, scan_ready, char_ready,
                  output char_data, char_valid);
endinterface

// File: rtl/kb_event_fifo.sv
// DEPTH-entry synchronous event FIFO with a registered head entry;
// push and pop in one cycle both proceed, even when full.
module kb_event_fifo
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              head_valid,
  output logic              full,
  output logic              drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BYTE_W-1:0] head_d;
  logic              pop_ok, push_ok, keep_old;

  assign pop_ok  = pop & head_valid;
  assign push_ok = push & (~full | pop_ok);
  assign drop_c  = push & full & ~pop_ok;

  // Next head: an older stored entry if one survives, else the incoming byte.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    keep_old = pop_ok ? (count_q > CNT_W'(1)) : (count_q != '0);
    if (keep_old)     head_d = mem[rd_ptr_d];
    else if (push_ok) head_d = push_data;
    else              head_d = '0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head       <= '0;
      head_valid <= 1'b0;
      full       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head       <= head_d;
      head_valid <= (count_d != '0);
      full       <= (count_d == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/kb_key_event_ctrl.sv
// PS/2 set-2 byte sequencer: prefix/shift tracking, make-code translation,
// event FIFO. Optional caps lock behind macro KB_CAPS_LOCK_EN.
module kb_key_event_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                resetn,
  kb_key_event_ctrl_if.slave  bus,
  output logic                shift_on,
  output logic                overflow,
  input  logic                clr_overflow,
  output logic                caps_on
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  kb_state_e         state_q, state_d;
  logic              shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              push, drop_c, fifo_full, upper;
  logic [BYTE_W-1:0] push_data;
  kb_map_t           map;
`ifdef KB_CAPS_LOCK_EN
  logic              caps_d;
`endif

  assign map   = kb_lookup(bus.scan_code);
  assign upper = shift_on ^ caps_on;

  // Next-state, prefix/shift tracking and event generation.
  always_comb begin
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    tmo_d     = tmo_q;
    push      = 1'b0;
    push_data = '0;
`ifdef KB_CAPS_LOCK_EN
    caps_d    = caps_on;
`endif
    if (bus.scan_ready) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (bus.scan_code == SC_BREAK)       state_d = S_BREAK;
          else if (bus.scan_code == SC_EXT)    state_d = S_EXT;
          else if (bus.scan_code == SC_LSHIFT) shift_l_d = 1'b1;
          else if (bus.scan_code == SC_RSHIFT) shift_r_d = 1'b1;
`ifdef KB_CAPS_LOCK_EN
          else if (bus.scan_code == SC_CAPS)   caps_d = ~caps_on;
`endif
          else if (map.hit) begin
            push      = 1'b1;
            push_data = (map.letter && upper) ? (map.code ^ CASE_BIT) : map.code;
          end
        end
        S_BREAK: begin
          state_d = S_IDLE;
          if (bus.scan_code == SC_LSHIFT)      shift_l_d = 1'b0;
          else if (bus.scan_code == SC_RSHIFT) shift_r_d = 1'b0;
        end
        S_EXT: begin
          if (bus.scan_code == SC_BREAK) begin
            state_d = S_EXT_BREAK;
          end else begin
            state_d = S_IDLE;
            case (bus.scan_code)
              SC_UP:    begin push = 1'b1; push_data = CH_UP;    end
              SC_DOWN:  begin push = 1'b1; push_data = CH_DOWN;  end
              SC_LEFT:  begin push = 1'b1; push_data = CH_LEFT;  end
              SC_RIGHT: begin push = 1'b1; push_data = CH_RIGHT; end
              default:  ;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      shift_on  <= 1'b0;
      tmo_q     <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      shift_on  <= shift_l_d | shift_r_d;
      tmo_q     <= tmo_d;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_c)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef KB_CAPS_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) caps_on <= 1'b0;
    else         caps_on <= caps_d;
  end
`else
  assign caps_on = 1'b0;
`endif

  kb_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_data  (push_data),
    .pop        (bus.char_ready),
    .head       (bus.char_data),
    .head_valid (bus.char_valid),
    .full       (fifo_full),
    .drop_c     (drop_c)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_kb_key_event_ctrl.sv
// Directed self-checking bench for kb_key_event_ctrl: byte-sequence table
// plus hand sequences for reset, overflow, timeout and mid-sequence reset.
module tb_kb_key_event_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic clr_overflow = 1'b0;
  logic shift_on, overflow, caps_on;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  kb_key_event_ctrl_if bus ();

  kb_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .shift_on     (shift_on),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .caps_on      (caps_on)
  );

  typedef struct packed {
    logic [3:0]  nb;
    logic [63:0] b;
    logic [2:0]  ne;
    logic [31:0] e;
    logic        shift;
    logic        caps;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input int nb, input logic [63:0] b, input int ne,
                              input logic [31:0] e, input logic sh, input logic cp);
    vec_t v;
    v.nb = 4'(nb); v.b = b; v.ne = 3'(ne); v.e = e; v.shift = sh; v.caps = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.scan_code  = b;
    bus.scan_ready = 1'b1;
    tick();
    bus.scan_ready = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, " valid"}, 32'(bus.char_valid), 32'd1);
    chk({name, " data"}, 32'(bus.char_data), 32'(exp));
    bus.char_ready = 1'b1;
    tick();
    bus.char_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] bt;
    bus.scan_code  = 8'h00;
    bus.scan_ready = 1'b0;
    bus.char_ready = 1'b0;

    vecs[0]  = mk(1, {8'h1C}, 1, {8'h61}, 1'b0, 1'b0);
    vecs[1]  = mk(7, {8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C}, 2, {8'h41, 8'h61}, 1'b0, 1'b0);
    vecs[2]  = mk(6, {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16}, 2, {8'h11, 8'h31}, 1'b0, 1'b0);
    vecs[3]  = mk(7, {8'hE0, 8'h72, 8'hE0, 8'h6B, 8'hE0, 8'h74, 8'h45}, 4, {8'h12, 8'h13, 8'h14, 8'h30}, 1'b0, 1'b0);
    vecs[4]  = mk(4, {8'h29, 8'h66, 8'h5A, 8'h46}, 4, {8'h20, 8'h08, 8'h0D, 8'h39}, 1'b0, 1'b0);
    vecs[5]  = mk(5, {8'h59, 8'h32, 8'hF0, 8'h59, 8'h1A}, 2, {8'h42, 8'h7A}, 1'b0, 1'b0);
    vecs[6]  = mk(2, {8'h59, 8'h15}, 1, {8'h51}, 1'b1, 1'b0);
    vecs[7]  = mk(3, {8'hF0, 8'h59, 8'h15}, 1, {8'h71}, 1'b0, 1'b0);
    vecs[8]  = mk(4, {8'h0E, 8'hE0, 8'h12, 8'h1C}, 1, {8'h61}, 1'b0, 1'b0);
    vecs[9]  = mk(3, {8'h1C, 8'h1C, 8'h1C}, 3, {8'h61, 8'h61, 8'h61}, 1'b0, 1'b0);
    vecs[10] = mk(4, {8'hE0, 8'hF0, 8'h72, 8'h16}, 1, {8'h31}, 1'b0, 1'b0);
`ifdef KB_CAPS_LOCK_EN
    vecs[11] = mk(8, {8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h58}, 2, {8'h41, 8'h61}, 1'b0, 1'b1);
`else
    vecs[11] = mk(8, {8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h58}, 2, {8'h61, 8'h41}, 1'b0, 1'b0);
`endif
    vecs[12] = mk(2, {8'h58, 8'h1C}, 1, {8'h61}, 1'b0, 1'b0);

    // Reset values
    tick(); tick();
    chk("rst char_valid", 32'(bus.char_valid), 32'd0);
    chk("rst char_data", 32'(bus.char_data), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst shift_on", 32'(shift_on), 32'd0);
    chk("rst caps_on", 32'(caps_on), 32'd0);
    resetn = 1'b1;
    tick();

    // Single-cycle latency and pop
    send(8'h1C);
    chk("lat valid", 32'(bus.char_valid), 32'd1);
    chk("lat data", 32'(bus.char_data), 32'h61);
    bus.char_ready = 1'b1;
    tick();
    bus.char_ready = 1'b0;
    chk("lat popped", 32'(bus.char_valid), 32'd0);

    // Shift visible the cycle after its byte
    send(8'h12);
    chk("shift set", 32'(shift_on), 32'd1);
    send(8'hF0);
    send(8'h12);
    chk("shift clr", 32'(shift_on), 32'd0);

    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < int'(vecs[v].nb); i++) begin
        bt = vecs[v].b[8*(int'(vecs[v].nb)-1-i) +: 8];
        send(bt);
        tick();
      end
      for (int j = 0; j < int'(vecs[v].ne); j++) begin
        bt = vecs[v].e[8*(int'(vecs[v].ne)-1-j) +: 8];
        pop_chk($sformatf("vec%0d ev%0d", v, j), bt);
      end
      chk($sformatf("vec%0d empty", v), 32'(bus.char_valid), 32'd0);
      chk($sformatf("vec%0d shift", v), 32'(shift_on), 32'(vecs[v].shift));
      chk($sformatf("vec%0d caps", v), 32'(caps_on), 32'(vecs[v].caps));
    end

    // Overflow, push+pop while full, clear, set-wins-over-clear
    repeat (DEPTH + 1) send(8'h16);
    chk("ovf set", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf clr", 32'(overflow), 32'd0);
    bus.char_ready = 1'b1;
    send(8'h1C);
    bus.char_ready = 1'b0;
    chk("ovf push+pop full", 32'(overflow), 32'd0);
    clr_overflow = 1'b1;
    send(8'h16);
    clr_overflow = 1'b0;
    chk("ovf set wins", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    pop_chk("ovf d0", 8'h31);
    pop_chk("ovf d1", 8'h31);
    pop_chk("ovf d2", 8'h31);
    pop_chk("ovf d3", 8'h61);
    chk("ovf drained", 32'(bus.char_valid), 32'd0);
    chk("ovf final", 32'(overflow), 32'd0);

    // Prefix still live well before the timeout
    send(8'hE0);
    repeat (TMO / 2) tick();
    send(8'h75);
    pop_chk("tmo early", 8'h11);

    // Timeout returns to idle
    send(8'hE0);
    repeat (TMO) tick();
    send(8'h1C);
    pop_chk("tmo expired", 8'h61);
    chk("tmo empty", 32'(bus.char_valid), 32'd0);

    // Reset mid-sequence discards FIFO and prefix
    send(8'h12);
    send(8'h1C);
    send(8'hE0);
    resetn = 1'b0;
    #2;
    chk("midrst valid", 32'(bus.char_valid), 32'd0);
    chk("midrst shift", 32'(shift_on), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    send(8'h1C);
    pop_chk("midrst idle", 8'h61);
    chk("midrst empty", 32'(bus.char_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
